// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, condition-code struct, multiply FSM states and the
// branch/cmov condition evaluator used by the execute stage.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] A_ADD = 4'h0;
   localparam logic [3:0] A_SUB = 4'h1;
   localparam logic [3:0] A_AND = 4'h2;
   localparam logic [3:0] A_XOR = 4'h3;
   localparam logic [3:0] A_MUL = 4'h4;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam logic [1:0] STAT_AOK = 2'd0;
   localparam logic [1:0] STAT_HLT = 2'd1;
   localparam logic [1:0] STAT_ADR = 2'd2;
   localparam logic [1:0] STAT_INS = 2'd3;

   localparam logic [3:0] REG_NONE = 4'hF;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   localparam cc_t CC_RESET = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DONE
   } mul_state_t;

   function automatic logic cond_eval(input cc_t cc, input logic [3:0] fun);
      logic w_lt;
      w_lt = cc.sf ^ cc.of;
      case (fun)
         C_YES:   cond_eval = 1'b1;
         C_LE:    cond_eval = w_lt | cc.zf;
         C_L:     cond_eval = w_lt;
         C_E:     cond_eval = cc.zf;
         C_NE:    cond_eval = ~cc.zf;
         C_GE:    cond_eval = ~w_lt;
         C_G:     cond_eval = ~w_lt & ~cc.zf;
         default: cond_eval = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/exe_alu_param.sv
// Combinational add/sub/and/xor ALU computing b op a, with ZF/SF/OF for the new
// condition-code value. Unsupported functions return 0.
module exe_alu_param
   import y86_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [3:0]        i_fun,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_result,
   output cc_t               o_flags
);

   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_diff;
   logic              w_ovf;

   assign w_sum  = i_b + i_a;
   assign w_diff = i_b - i_a;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      o_result = '0;
      w_ovf    = 1'b0;
      case (i_fun)
         A_ADD: begin
            o_result = w_sum;
            w_ovf    = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_sum[DATA_W-1] != i_b[DATA_W-1]);
         end
         A_SUB: begin
            o_result = w_diff;
            w_ovf    = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_diff[DATA_W-1] != i_b[DATA_W-1]);
         end
         A_AND:   o_result = i_b & i_a;
         A_XOR:   o_result = i_b ^ i_a;
         default: o_result = '0;
      endcase
   end

   assign o_flags = '{zf: (o_result == '0), sf: o_result[DATA_W-1], of: w_ovf};

endmodule

// File: rtl/pipe_execute_param.sv
// Y86-64 execute stage with E->M register, condition codes and iterative mulq.
// Optional macro EXE_PERF_CNT_EN adds perf_insn/perf_bubble M-load counters.
module pipe_execute_param #(
   parameter int         DATA_W    = 64,
   parameter logic [3:0] REG_NONE  = 4'hF,
   parameter int         MUL_CNT_W = 7
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [1:0]        E_stat,
   input  logic [3:0]        E_in_code,
   input  logic [3:0]        E_in_fun,
   input  logic [DATA_W-1:0] E_val_a,
   input  logic [DATA_W-1:0] E_val_b,
   input  logic [DATA_W-1:0] E_val_c,
   input  logic [3:0]        E_dst_e,
   input  logic [3:0]        E_dst_m,
   input  logic              set_cc,
   input  logic              M_stall,
   input  logic              M_bubble,
   output logic              e_busy,
   output logic              e_cnd,
   output logic [3:0]        e_dst_e,
   output logic [DATA_W-1:0] e_val_e,
   output logic [2:0]        cc_out,
   output logic [1:0]        M_stat,
   output logic [3:0]        M_in_code,
   output logic [DATA_W-1:0] M_val_e,
   output logic [DATA_W-1:0] M_val_a,
   output logic [3:0]        M_dst_e,
   output logic [3:0]        M_dst_m,
   output logic              M_cnd
`ifdef EXE_PERF_CNT_EN
   ,
   output logic [31:0]       perf_insn,
   output logic [31:0]       perf_bubble
`endif
);

   import y86_pkg::*;

   localparam logic [MUL_CNT_W-1:0] CNT_ONE  = MUL_CNT_W'(1);
   localparam logic [MUL_CNT_W-1:0] CNT_LOAD = MUL_CNT_W'(DATA_W);
   localparam logic [DATA_W-1:0]    STACK_ADJ = DATA_W'(8);

   logic [DATA_W-1:0]    w_alu_res;
   cc_t                  w_alu_flags;
   logic [DATA_W-1:0]    w_mul_res;
   cc_t                  w_mul_flags;
   logic [DATA_W-1:0]    w_val_e;
   cc_t                  w_new_cc;
   logic                 w_is_mul;
   logic                 w_mul_start;
   logic                 w_m_load_e;
   logic                 w_cc_we;

   mul_state_t           r_state;
   logic [DATA_W-1:0]    r_acc;
   logic [DATA_W-1:0]    r_mcand;
   logic [DATA_W-1:0]    r_mplier;
   logic [MUL_CNT_W-1:0] r_cnt;
   cc_t                  r_cc;

   logic [1:0]           r_m_stat;
   logic [3:0]           r_m_in_code;
   logic [DATA_W-1:0]    r_m_val_e;
   logic [DATA_W-1:0]    r_m_val_a;
   logic [3:0]           r_m_dst_e;
   logic [3:0]           r_m_dst_m;
   logic                 r_m_cnd;

   exe_alu_param #(.DATA_W(DATA_W)) u_alu (
      .i_fun    (E_in_fun),
      .i_a      (E_val_a),
      .i_b      (E_val_b),
      .o_result (w_alu_res),
      .o_flags  (w_alu_flags)
   );

   // Busy must drop the instant reset asserts, even with mulq still sitting in E.
   assign w_is_mul    = (E_in_code == I_OPQ) && (E_in_fun == A_MUL);
   assign w_mul_start = reset_n && (r_state == ST_IDLE) && w_is_mul &&
                        (E_stat == STAT_AOK) && !M_stall;
   assign e_busy      = w_mul_start || (r_state == ST_MUL);

   assign w_mul_res   = (r_state == ST_DONE) ? r_acc : '0;
   assign w_mul_flags = '{zf: (w_mul_res == '0), sf: w_mul_res[DATA_W-1], of: 1'b0};

   always_comb begin
      w_val_e  = '0;
      w_new_cc = r_cc;
      case (E_in_code)
         I_RRMOVQ:           w_val_e = E_val_a;
         I_IRMOVQ:           w_val_e = E_val_c;
         I_RMMOVQ, I_MRMOVQ: w_val_e = E_val_b + E_val_c;
         I_OPQ: begin
            if (E_in_fun == A_MUL) begin
               w_val_e  = w_mul_res;
               w_new_cc = w_mul_flags;
            end else begin
               w_val_e  = w_alu_res;
               w_new_cc = w_alu_flags;
            end
         end
         I_CALL, I_PUSHQ:    w_val_e = E_val_b - STACK_ADJ;
         I_RET, I_POPQ:      w_val_e = E_val_b + STACK_ADJ;
         default:            w_val_e = '0;
      endcase
   end

   assign e_val_e = w_val_e;
   assign e_cnd   = ((E_in_code == I_RRMOVQ) || (E_in_code == I_JXX)) ? cond_eval(r_cc, E_in_fun) : 1'b0;
   assign e_dst_e = ((E_in_code == I_RRMOVQ) && !e_cnd) ? REG_NONE : E_dst_e;
   assign cc_out  = r_cc;

   assign w_m_load_e = !M_stall && !M_bubble && !e_busy;
   assign w_cc_we    = w_m_load_e && (E_in_code == I_OPQ) && (E_in_fun <= A_MUL) &&
                       (E_stat == STAT_AOK) && set_cc;

   // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_mul_start) begin
                  r_state  <= ST_MUL;
                  r_acc    <= '0;
                  r_mcand  <= E_val_b;
                  r_mplier <= E_val_a;
                  r_cnt    <= CNT_LOAD;
               end
            end
            ST_MUL: begin
               if (r_mplier[0]) r_acc <= r_acc + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) r_state <= ST_DONE;
            end
            ST_DONE: begin
               if (!M_stall) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_cc <= CC_RESET;
      else if (w_cc_we) r_cc <= w_new_cc;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_m_stat    <= STAT_AOK;
         r_m_in_code <= I_NOP;
         r_m_val_e   <= '0;
         r_m_val_a   <= '0;
         r_m_dst_e   <= REG_NONE;
         r_m_dst_m   <= REG_NONE;
         r_m_cnd     <= 1'b0;
      end else if (M_stall) begin
         r_m_stat    <= r_m_stat;
      end else if (M_bubble || e_busy) begin
         r_m_stat    <= STAT_AOK;
         r_m_in_code <= I_NOP;
         r_m_val_e   <= '0;
         r_m_val_a   <= '0;
         r_m_dst_e   <= REG_NONE;
         r_m_dst_m   <= REG_NONE;
         r_m_cnd     <= 1'b0;
      end else begin
         r_m_stat    <= E_stat;
         r_m_in_code <= E_in_code;
         r_m_val_e   <= w_val_e;
         r_m_val_a   <= E_val_a;
         r_m_dst_e   <= e_dst_e;
         r_m_dst_m   <= E_dst_m;
         r_m_cnd     <= e_cnd;
      end
   end

   assign M_stat    = r_m_stat;
   assign M_in_code = r_m_in_code;
   assign M_val_e   = r_m_val_e;
   assign M_val_a   = r_m_val_a;
   assign M_dst_e   = r_m_dst_e;
   assign M_dst_m   = r_m_dst_m;
   assign M_cnd     = r_m_cnd;

`ifdef EXE_PERF_CNT_EN
   logic [31:0] r_perf_insn;
   logic [31:0] r_perf_bubble;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_insn   <= '0;
         r_perf_bubble <= '0;
      end else if (!M_stall) begin
         if (M_bubble || e_busy) r_perf_bubble <= r_perf_bubble + 32'd1;
         else                    r_perf_insn   <= r_perf_insn + 32'd1;
      end
   end

   assign perf_insn   = r_perf_insn;
   assign perf_bubble = r_perf_bubble;
`endif

endmodule

// File: tb/tb_pipe_execute_param.sv
// Directed self-checking bench for pipe_execute_param at DATA_W=64; perf counter
// checks are compiled in when EXE_PERF_CNT_EN is defined.
module tb_pipe_execute_param;
   import y86_pkg::*;

   localparam int DW = 64;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [1:0]    E_stat;
   logic [3:0]    E_in_code, E_in_fun;
   logic [DW-1:0] E_val_a, E_val_b, E_val_c;
   logic [3:0]    E_dst_e, E_dst_m;
   logic          set_cc, M_stall, M_bubble;
   logic          e_busy, e_cnd;
   logic [3:0]    e_dst_e;
   logic [DW-1:0] e_val_e;
   logic [2:0]    cc_out;
   logic [1:0]    M_stat;
   logic [3:0]    M_in_code;
   logic [DW-1:0] M_val_e, M_val_a;
   logic [3:0]    M_dst_e, M_dst_m;
   logic          M_cnd;
`ifdef EXE_PERF_CNT_EN
   logic [31:0]   perf_insn, perf_bubble;
`endif

   int n_pass  = 0;
   int n_total = 0;

   pipe_execute_param #(.DATA_W(DW), .REG_NONE(4'hF), .MUL_CNT_W(7)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .E_stat    (E_stat),
      .E_in_code (E_in_code),
      .E_in_fun  (E_in_fun),
      .E_val_a   (E_val_a),
      .E_val_b   (E_val_b),
      .E_val_c   (E_val_c),
      .E_dst_e   (E_dst_e),
      .E_dst_m   (E_dst_m),
      .set_cc    (set_cc),
      .M_stall   (M_stall),
      .M_bubble  (M_bubble),
      .e_busy    (e_busy),
      .e_cnd     (e_cnd),
      .e_dst_e   (e_dst_e),
      .e_val_e   (e_val_e),
      .cc_out    (cc_out),
      .M_stat    (M_stat),
      .M_in_code (M_in_code),
      .M_val_e   (M_val_e),
      .M_val_a   (M_val_a),
      .M_dst_e   (M_dst_e),
      .M_dst_m   (M_dst_m),
      .M_cnd     (M_cnd)
`ifdef EXE_PERF_CNT_EN
      ,
      .perf_insn   (perf_insn),
      .perf_bubble (perf_bubble)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic drive(input logic [1:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                        input logic [3:0] dste, input logic [3:0] dstm);
      E_stat = stat; E_in_code = icode; E_in_fun = ifun;
      E_val_a = va; E_val_b = vb; E_val_c = vc;
      E_dst_e = dste; E_dst_m = dstm;
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic nop_in;
      drive(STAT_AOK, I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
      set_cc = 1'b0;
   endtask

   // Runs a mulq already driven on E: counts busy cycles, checks bubbles, then the product.
   task automatic run_mul(input string tag, input logic [63:0] exp_prod, input logic [2:0] exp_cc);
      int n_busy;
      bit bub_ok;
      n_busy = 0;
      bub_ok = 1'b1;
      @(negedge clock);
      while (e_busy === 1'b1 && n_busy < 200) begin
         n_busy++;
         @(posedge clock);
         #1;
         if (M_in_code !== I_NOP || M_dst_e !== 4'hF) bub_ok = 1'b0;
         @(negedge clock);
      end
      check({tag, "_busy_cycles"}, 64'(n_busy), 64'(DW + 1));
      check({tag, "_bubbles"}, 64'(bub_ok), 64'h1);
      check({tag, "_e_val_e"}, e_val_e, exp_prod);
      step;
      check({tag, "_M_val_e"}, M_val_e, exp_prod);
      check({tag, "_M_in_code"}, 64'(M_in_code), 64'(I_OPQ));
      check({tag, "_cc"}, 64'(cc_out), 64'(exp_cc));
      nop_in;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b1; M_stall = 1'b0; M_bubble = 1'b0;
      nop_in;

      // Asynchronous reset before any clock edge
      #3 reset_n = 1'b0;
      #1;
      check("rst_M_in_code", 64'(M_in_code), 64'h1);
      check("rst_M_dst_e",   64'(M_dst_e),   64'hF);
      check("rst_cc",        64'(cc_out),    64'h4);
      check("rst_busy",      64'(e_busy),    64'h0);
      @(negedge clock) reset_n = 1'b1;
      step;

      // subq: 5 - 7
      drive(STAT_AOK, I_OPQ, A_SUB, 64'd7, 64'd5, 64'h0, 4'h3, 4'hF);
      set_cc = 1'b1;
      #2 check("sub_e_val_e", e_val_e, 64'hFFFF_FFFF_FFFF_FFFE);
      step;
      check("sub_M_val_e", M_val_e, 64'hFFFF_FFFF_FFFF_FFFE);
      check("sub_cc",      64'(cc_out), 64'h2);
      check("sub_M_dst_e", 64'(M_dst_e), 64'h3);

      // addq to zero with set_cc low leaves CC alone
      drive(STAT_AOK, I_OPQ, A_ADD, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'h3, 4'hF);
      set_cc = 1'b0;
      step;
      check("add_nocc_M_val_e", M_val_e, 64'h0);
      check("add_nocc_cc",      64'(cc_out), 64'h2);

      // cmove with ZF=0: not taken
      drive(STAT_AOK, I_RRMOVQ, C_E, 64'h1234, 64'h0, 64'h0, 4'h3, 4'hF);
      #2;
      check("cmov_nt_e_cnd",   64'(e_cnd),   64'h0);
      check("cmov_nt_e_dst_e", 64'(e_dst_e), 64'hF);
      step;
      check("cmov_nt_M_dst_e", 64'(M_dst_e), 64'hF);

      // xorq equal operands -> ZF=1
      drive(STAT_AOK, I_OPQ, A_XOR, 64'h55, 64'h55, 64'h0, 4'h2, 4'hF);
      set_cc = 1'b1;
      step;
      check("xor_cc", 64'(cc_out), 64'h4);

      // cmove with ZF=1: taken
      drive(STAT_AOK, I_RRMOVQ, C_E, 64'h1234, 64'h0, 64'h0, 4'h3, 4'hF);
      set_cc = 1'b0;
      #2 check("cmov_t_e_cnd", 64'(e_cnd), 64'h1);
      step;
      check("cmov_t_M_dst_e", 64'(M_dst_e), 64'h3);
      check("cmov_t_M_val_e", M_val_e, 64'h1234);
      check("cmov_t_M_cnd",   64'(M_cnd), 64'h1);

      // jle / jg with CC = {1,0,0}
      drive(STAT_AOK, I_JXX, C_LE, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
      #2 check("jle_e_cnd", 64'(e_cnd), 64'h1);
      E_in_fun = C_G;
      #1 check("jg_e_cnd", 64'(e_cnd), 64'h0);
      step;

      // addq signed overflow
      drive(STAT_AOK, I_OPQ, A_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 4'h1, 4'hF);
      set_cc = 1'b1;
      step;
      check("ovf_M_val_e", M_val_e, 64'h8000_0000_0000_0000);
      check("ovf_cc",      64'(cc_out), 64'h3);

      // undefined OPq function: zero result, CC untouched
      drive(STAT_AOK, I_OPQ, 4'h7, 64'd1, 64'd1, 64'h0, 4'h1, 4'hF);
      #2 check("badfun_e_val_e", e_val_e, 64'h0);
      step;
      check("badfun_cc", 64'(cc_out), 64'h3);

      // non-AOK OPq flows to M without touching CC
      drive(STAT_ADR, I_OPQ, A_ADD, 64'h0, 64'h0, 64'h0, 4'h1, 4'hF);
      step;
      check("adr_cc",     64'(cc_out), 64'h3);
      check("adr_M_stat", 64'(M_stat), 64'h2);

      // irmovq, then stall+bubble holds, bubble alone flushes
      drive(STAT_AOK, I_IRMOVQ, 4'h0, 64'h0, 64'h0, 64'hAB, 4'h2, 4'hF);
      set_cc = 1'b0;
      step;
      check("irmov_M_val_e", M_val_e, 64'hAB);
      drive(STAT_AOK, I_PUSHQ, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4, 4'hF);
      M_stall = 1'b1; M_bubble = 1'b1;
      #2 check("push_e_val_e", e_val_e, 64'hF8);
      step;
      check("hold_M_val_e",   M_val_e, 64'hAB);
      check("hold_M_in_code", 64'(M_in_code), 64'(I_IRMOVQ));
      M_stall = 1'b0;
      step;
      check("bub_M_in_code", 64'(M_in_code), 64'h1);
      check("bub_M_dst_e",   64'(M_dst_e), 64'hF);
      check("bub_M_val_e",   M_val_e, 64'h0);
      M_bubble = 1'b0;
      step;
      check("push_M_val_e", M_val_e, 64'hF8);
      drive(STAT_AOK, I_POPQ, 4'h0, 64'h100, 64'h100, 64'h0, 4'h4, 4'h6);
      step;
      check("pop_M_val_e", M_val_e, 64'h108);
      check("pop_M_dst_m", 64'(M_dst_m), 64'h6);

      // mulq 0x1_0000_0003 * 5
      drive(STAT_AOK, I_OPQ, A_MUL, 64'd5, 64'h1_0000_0003, 64'h0, 4'h5, 4'hF);
      set_cc = 1'b1;
      run_mul("mul1", 64'h5_0000_000F, 3'b000);

      // mulq blocked while M stalls, then reset mid-multiply
      drive(STAT_AOK, I_OPQ, A_MUL, 64'd3, 64'd3, 64'h0, 4'h5, 4'hF);
      set_cc = 1'b1; M_stall = 1'b1;
      #2 check("mul_stall_nostart", 64'(e_busy), 64'h0);
      step;
      M_stall = 1'b0;
      repeat (4) step;
      #2 check("mul_mid_busy", 64'(e_busy), 64'h1);
      reset_n = 1'b0;
      #1;
      check("mul_rst_busy",      64'(e_busy), 64'h0);
      check("mul_rst_M_in_code", 64'(M_in_code), 64'h1);
      check("mul_rst_cc",        64'(cc_out), 64'h4);
      nop_in;
      @(negedge clock) reset_n = 1'b1;
      step;

      // multiply after reset starts from a clean accumulator
      drive(STAT_AOK, I_OPQ, A_MUL, 64'd3, 64'd7, 64'h0, 4'h5, 4'hF);
      set_cc = 1'b1;
      run_mul("mul2", 64'h15, 3'b000);

`ifdef EXE_PERF_CNT_EN
      reset_n = 1'b0;
      #1;
      check("perf_rst_insn",   64'(perf_insn),   64'h0);
      check("perf_rst_bubble", 64'(perf_bubble), 64'h0);
      @(negedge clock) reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         M_bubble = (i == 3) || (i == 7);
         step;
      end
      M_bubble = 1'b0; M_stall = 1'b1;
      step;
      M_stall = 1'b0;
      check("perf_insn",   64'(perf_insn),   64'd8);
      check("perf_bubble", 64'(perf_bubble), 64'd2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipe_execute_param.md
Name: pipe_execute_param

Overview:
Parametrised Y86-64 execute stage with its E->M pipeline register. It reads the decoded E-register fields and computes val_e, the branch/cmov condition and the effective destination. It holds a resettable condition-code register, supports stall and bubble control of the M register, and adds a multi-cycle iterative multiply (OPq ifun 4, mulq). It sits between the decode-stage E register and the memory stage.

Parameters:
DATA_W, 64, datapath width of val_a/val_b/val_c/val_e; legal values 8..64, multiple of 8
REG_NONE, 4'hF, register ID meaning "no destination"
MUL_CNT_W, 7, width of the multiply iteration counter; must satisfy 2^MUL_CNT_W > DATA_W

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
E_stat  in  2  stat of the instruction in E (0 AOK, 1 HLT, 2 ADR, 3 INS)
E_in_code / E_in_fun  in  4/4  icode / ifun
E_val_a / E_val_b / E_val_c  in  DATA_W each  operands
E_dst_e / E_dst_m  in  4/4  destination register IDs
set_cc  in  1  from hazard unit; 0 blocks CC update
M_stall / M_bubble  in  1/1  hold / flush the M register
e_busy  out  1  multiply in progress; hazard unit must stall F/D/E
e_cnd  out  1  combinational condition result
e_dst_e  out  4  effective destination (REG_NONE if cmov not taken)
e_val_e  out  DATA_W  combinational result, used for forwarding
cc_out  out  3  {ZF,SF,OF}
M_stat / M_in_code  out  2/4  registered
M_val_e / M_val_a  out  DATA_W each  registered
M_dst_e / M_dst_m  out  4/4  registered
M_cnd  out  1  registered

Behaviour:
- val_e by icode:
  - 2 (rrmov/cmov): val_a
  - 3: val_c
  - 4, 5: val_b+val_c
  - 6: ALU
  - 8, 10: val_b-8
  - 9, 11: val_b+8
  - all others: 0
- Stack adjust is 8, not 1. All arithmetic is modulo 2^DATA_W.
- ALU (val_b op val_a):
  - ifun 0 add, 1 sub (val_b-val_a), 2 and, 3 xor, 4 mul (unsigned low DATA_W bits of product).
  - ifun 5-15 produce val_e=0 with no CC update.
- Flags for the new CC value:
  - ZF = (result==0); SF = result[DATA_W-1].
  - OF = signed overflow for add/sub; 0 for and/xor/mul.
- CC write: written on the edge where M loads an icode-6 instruction with E_stat==AOK and set_cc=1; otherwise held.
- Reset value: ZF=1, SF=0, OF=0.
- e_cnd (icode 2 and 7, from current CC):
  - ifun 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g.
  - Other ifun, and all other icodes: e_cnd=0.
- e_dst_e = REG_NONE when icode 2 and !e_cnd; else E_dst_e.
- Multiply FSM, states IDLE, MUL, DONE:
  - IDLE->MUL when icode 6, ifun 4, E_stat==AOK and !M_stall. This loads the accumulator with 0 and the counter with DATA_W.
  - MUL runs shift-add, one multiplier bit per cycle, and decrements the counter. At 0 it goes to DONE.
  - DONE: e_val_e = product; M loads it. Then go to IDLE, or stay in DONE while M_stall is high.
  - e_busy=1 in the IDLE cycle that detects mulq and throughout MUL; 0 in DONE.
  - Occupancy in E: DATA_W+2 cycles.
- M register priority per edge:
  1. M_stall: hold.
  2. M_bubble or e_busy: load bubble (icode 1, stat 0, dst_e/dst_m REG_NONE, val 0, cnd 0).
  3. Otherwise load E values (M_val_e<=e_val_e, M_dst_e<=e_dst_e, M_cnd<=e_cnd, rest from E_*).
- Reset (asynchronous, any time including mid-multiply):
  - M outputs take the bubble values.
  - FSM goes to IDLE, e_busy=0, CC reset, accumulator cleared.
- Non-AOK E_stat never starts a multiply and never writes CC, but the instruction still flows to M.

Optional Feature:
- Macro EXE_PERF_CNT_EN.
- Defined: adds outputs perf_insn (32 bits) and perf_bubble (32 bits). They count M loads of non-bubble instructions and bubble loads; they are reset to 0, wrap modulo 2^32 and do not change while M_stall is high.
- Undefined: the ports and logic do not exist; all other behaviour is identical.

Decomposition:
- Package y86_pkg holds:
  - icode/ifun constants, stat codes and REG_NONE;
  - the cc_t struct {zf,sf,of};
  - the mul FSM state enum.
- One sub-module, exe_alu_param (combinational add/sub/and/xor plus flag generation, parametrised on DATA_W). The iterative multiplier stays in the top module.

Test Plan:
- Reset: drive reset_n low asynchronously mid-cycle -> M_in_code=1, M_dst_e=F, cc_out=3'b100, e_busy=0 without waiting for a clock edge.
- OPq: ifun 1, val_b=5, val_a=7, set_cc=1 -> M_val_e=0xFFFF_FFFF_FFFF_FFFE, cc_out=3'b010. Repeat with set_cc=0 -> CC unchanged.
- cmov: icode 2 ifun 3 with ZF=0, E_dst_e=3 -> e_cnd=0, M_dst_e=F. With ZF=1 -> M_dst_e=3, M_val_e=val_a.
- mulq: DATA_W=64, val_b=0x1_0000_0003, val_a=5 -> e_busy high for 65 cycles and M gets bubbles; then M_val_e=0x5_0000_000F, ZF=0, OF=0. Assert reset mid-multiply -> IDLE and busy=0 immediately.
- Stall/bubble: M_stall=1 and M_bubble=1 together -> M holds. M_bubble alone -> bubble loaded. pushq val_b=0x100 -> M_val_e=0xF8; popq -> 0x108.
- EXE_PERF_CNT_EN: run 10 instructions including 2 bubbles -> perf_insn=8, perf_bubble=2; both 0 after reset.
